// File: rtl/biriscv_icache_lite.sv
// rtl/biriscv_icache_lite.sv - direct-mapped read-only instruction cache with line refill
// Build option ICACHE_CRITICAL_WORD_EN: respond as soon as the requested beat arrives.
module biriscv_icache_lite #(
   parameter int NUM_LINES    = 64,
   parameter int NUM_LINES_W  = 6,
   parameter int LINE_BEATS   = 4,
   parameter int LINE_BEATS_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_rd_i,
   input  logic        req_flush_i,
   input  logic        req_invalidate_i,
   input  logic [31:0] req_pc_i,
   input  logic [1:0]  req_priv_i,
   output logic        req_accept_o,
   output logic        req_valid_o,
   output logic [63:0] req_inst_o,
   output logic        req_error_o,
   output logic        req_page_fault_o,
   output logic        mem_rd_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_accept_i,
   input  logic        mem_valid_i,
   input  logic [63:0] mem_data_i,
   input  logic        mem_error_i
);
   localparam int OFFS_W = 3 + LINE_BEATS_W;
   localparam int TAG_W  = 32 - OFFS_W - NUM_LINES_W;
   localparam int RAM_AW = NUM_LINES_W + LINE_BEATS_W;

   typedef enum logic [2:0] {
      S_INIT,
      S_LOOKUP,
      S_REFILL_REQ,
      S_REFILL,
      S_FLUSH
   } state_t;

   state_t state_q, state_d;

   logic [NUM_LINES-1:0]    valid_q;
   logic [TAG_W-1:0]        tag_q [NUM_LINES];
   logic [63:0]             ram [NUM_LINES*LINE_BEATS];
   logic [63:0]             ram_q;
   logic [RAM_AW-1:0]       ram_addr;
   logic                    ram_we;

   logic [NUM_LINES_W-1:0]  walk_q;
   logic [LINE_BEATS_W-1:0] beat_q;
   logic                    lk_valid_q;
   logic [31:0]             lk_pc_q;
   logic                    err_q;
   logic                    flush_pend_q;
   logic                    resp_pulse_q;
   logic                    resp_err_q;
   logic [63:0]             resp_data_q;

   logic [LINE_BEATS_W-1:0] req_beat, lk_beat;
   logic [NUM_LINES_W-1:0]  req_index, lk_index;
   logic [TAG_W-1:0]        lk_tag;
   logic                    hit, hit_resp, lookup_miss, accept;
   logic                    take_flush, take_inv, take_rd;
   logic                    beat_fire, last_beat, line_err, walk_done;

   assign req_beat  = req_pc_i[3 +: LINE_BEATS_W];
   assign req_index = req_pc_i[OFFS_W +: NUM_LINES_W];
   assign lk_beat   = lk_pc_q[3 +: LINE_BEATS_W];
   assign lk_index  = lk_pc_q[OFFS_W +: NUM_LINES_W];
   assign lk_tag    = lk_pc_q[OFFS_W+NUM_LINES_W +: TAG_W];

   assign hit         = lk_valid_q && valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
   assign hit_resp    = (state_q == S_LOOKUP) && hit;
   assign lookup_miss = (state_q == S_LOOKUP) && lk_valid_q && !hit;
   assign accept      = (state_q == S_LOOKUP) && !lookup_miss;

   assign take_flush = accept && req_flush_i;
   assign take_inv   = accept && !req_flush_i && req_invalidate_i;
   assign take_rd    = accept && !req_flush_i && !req_invalidate_i && req_rd_i;

   assign beat_fire = (state_q == S_REFILL) && mem_valid_i;
   assign last_beat = beat_fire && (beat_q == LINE_BEATS_W'(LINE_BEATS-1));
   assign line_err  = err_q || mem_error_i;
   assign walk_done = (walk_q == NUM_LINES_W'(NUM_LINES-1));

   logic unused_bits;
   assign unused_bits = ^{req_priv_i, lk_pc_q[2:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:       if (walk_done) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (take_flush)       state_d = S_FLUSH;
            else if (lookup_miss) state_d = S_REFILL_REQ;
         end
         S_REFILL_REQ: if (mem_accept_i) state_d = S_REFILL;
         S_REFILL: begin
            if (last_beat) state_d = (flush_pend_q || req_flush_i) ? S_FLUSH : S_LOOKUP;
         end
         S_FLUSH:      if (walk_done) state_d = S_LOOKUP;
         default:      state_d = S_INIT;
      endcase
   end

   // A refill response owns the output in the cycle it is pending; hits cannot coincide with it.
   always_comb begin
      req_accept_o     = accept;
      req_valid_o      = resp_pulse_q || hit_resp;
      req_error_o      = resp_pulse_q && resp_err_q;
      req_page_fault_o = 1'b0;
      req_inst_o       = '0;
      if (resp_pulse_q)  req_inst_o = resp_err_q ? 64'd0 : resp_data_q;
      else if (hit_resp) req_inst_o = ram_q;
      mem_rd_o         = (state_q == S_REFILL_REQ);
      mem_addr_o       = mem_rd_o ? {lk_pc_q[31:OFFS_W], {OFFS_W{1'b0}}} : 32'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         walk_q       <= '0;
         lk_valid_q   <= 1'b0;
         lk_pc_q      <= '0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         flush_pend_q <= 1'b0;
         resp_pulse_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         if (state_q == S_INIT || state_q == S_FLUSH) walk_q <= walk_q + 1'b1;

         lk_valid_q <= take_rd;
         if (take_rd) lk_pc_q <= req_pc_i;

         if (state_q == S_REFILL_REQ) begin
            beat_q <= '0;
            err_q  <= 1'b0;
         end else if (beat_fire) begin
            beat_q <= beat_q + 1'b1;
            if (mem_error_i) err_q <= 1'b1;
         end

         if (state_q == S_FLUSH)
            flush_pend_q <= 1'b0;
         else if (req_flush_i && (lookup_miss || state_q == S_REFILL_REQ || state_q == S_REFILL))
            flush_pend_q <= 1'b1;

         resp_pulse_q <= 1'b0;
         if (beat_fire && beat_q == lk_beat) begin
            resp_data_q <= mem_data_i;
`ifdef ICACHE_CRITICAL_WORD_EN
            resp_pulse_q <= 1'b1;
            resp_err_q   <= line_err;
`endif
         end
`ifndef ICACHE_CRITICAL_WORD_EN
         if (last_beat) begin
            resp_pulse_q <= 1'b1;
            resp_err_q   <= line_err;
         end
`endif
      end
   end

   // Valid bits have no reset of their own: reset enters INIT, which walks them clear.
   always_ff @(posedge clk_i) begin
      if (state_q == S_INIT || state_q == S_FLUSH)
         valid_q[walk_q] <= 1'b0;
      else if (take_inv)
         valid_q[req_index] <= 1'b0;
      else if (last_beat)
         valid_q[lk_index] <= !line_err;
   end

   always_ff @(posedge clk_i) begin
      if (last_beat) tag_q[lk_index] <= lk_tag;
   end

   assign ram_we   = beat_fire;
   assign ram_addr = ram_we ? {lk_index, beat_q} : {req_index, req_beat};

   always_ff @(posedge clk_i) begin
      if (ram_we) ram[ram_addr] <= mem_data_i;
      ram_q <= ram[ram_addr];
   end
endmodule
